// File: rtl/monitor_limites.sv
// Limit monitor: scans four temperatures and one humidity through one shared comparator,
// with an N-sample confirmation filter. Define HISTERESE_EN to lower the clear threshold by HIST.
module monitor_limites #(
    parameter int N_CONFIRMA = 3,
    parameter int HIST       = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic [15:0] temp1,
    input  logic [15:0] temp2,
    input  logic [15:0] temp3,
    input  logic [15:0] temp4,
    input  logic [15:0] umidade,
    input  logic [15:0] temp_lim1,
    input  logic [15:0] temp_lim2,
    input  logic [15:0] temp_lim3,
    input  logic [15:0] temp_lim4,
    input  logic [15:0] umidade_lim,
    output logic [3:0]  alarme_temp,
    output logic        alarme_umidade,
    output logic        alarme_algum,
    output logic        pronto,
    output logic        ocupado,
    output logic [1:0]  db_estado
);
    typedef enum logic [1:0] {OCIOSO = 2'd0, COMPARA = 2'd1, FIM = 2'd2} estado_t;

    localparam int         NCH    = 5;
    localparam logic [3:0] N_CONF = 4'(N_CONFIRMA);

    estado_t     r_estado, w_prox;
    logic [2:0]  r_canal;
    logic [15:0] r_valor  [NCH];
    logic [15:0] r_limite [NCH];
    logic [3:0]  r_cnt    [NCH];
    logic [4:0]  r_alarme;

    logic [15:0] w_valor, w_limite, w_baixo;
    logic [3:0]  w_cnt, w_cnt_inc;
    logic        w_alarme, w_cond, w_confirma;

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_estado <= OCIOSO;
        else       r_estado <= w_prox;
    end

    // Next-state logic
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            OCIOSO:  if (medir) w_prox = COMPARA;
            COMPARA: if (r_canal == 3'd4) w_prox = FIM;
            FIM:     w_prox = OCIOSO;
            default: w_prox = OCIOSO;
        endcase
    end

    // Output logic
    always_comb begin
        pronto    = (r_estado == FIM);
        ocupado   = (r_estado == COMPARA) || (r_estado == FIM);
        db_estado = r_estado;
    end

    // Shared comparator: select the channel under scan
    always_comb begin
        w_valor  = r_valor[4];
        w_limite = r_limite[4];
        w_cnt    = r_cnt[4];
        w_alarme = r_alarme[4];
        for (int i = 0; i < NCH - 1; i++) begin
            if (r_canal == 3'(i)) begin
                w_valor  = r_valor[i];
                w_limite = r_limite[i];
                w_cnt    = r_cnt[i];
                w_alarme = r_alarme[i];
            end
        end
    end

`ifdef HISTERESE_EN
    localparam logic [15:0] HIST_V = 16'(HIST);
    assign w_baixo = (w_limite >= HIST_V) ? (w_limite - HIST_V) : 16'd0;
`else
    assign w_baixo = w_limite;
`endif

    // An armed alarm looks for the clear condition, an idle one for excess
    assign w_cond     = w_alarme ? (w_valor <= w_baixo) : (w_valor > w_limite);
    assign w_cnt_inc  = w_cnt + 4'd1;
    assign w_confirma = (w_cnt_inc == N_CONF);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_canal  <= '0;
            r_alarme <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_valor[i]  <= '0;
                r_limite[i] <= '0;
                r_cnt[i]    <= '0;
            end
        end else if (r_estado == OCIOSO && medir) begin
            r_canal     <= '0;
            r_valor[0]  <= temp1;
            r_valor[1]  <= temp2;
            r_valor[2]  <= temp3;
            r_valor[3]  <= temp4;
            r_valor[4]  <= umidade;
            r_limite[0] <= temp_lim1;
            r_limite[1] <= temp_lim2;
            r_limite[2] <= temp_lim3;
            r_limite[3] <= temp_lim4;
            r_limite[4] <= umidade_lim;
        end else if (r_estado == COMPARA) begin
            r_canal <= r_canal + 3'd1;
            for (int i = 0; i < NCH; i++) begin
                if (r_canal == 3'(i)) begin
                    if (!w_cond) begin
                        r_cnt[i] <= '0;
                    end else if (w_confirma) begin
                        r_cnt[i]    <= '0;
                        r_alarme[i] <= ~r_alarme[i];
                    end else begin
                        r_cnt[i] <= w_cnt_inc;
                    end
                end
            end
        end
    end

    assign alarme_temp    = r_alarme[3:0];
    assign alarme_umidade = r_alarme[4];
    assign alarme_algum   = |r_alarme;
endmodule

// File: tb/tb_monitor_limites.sv
// Directed bench for monitor_limites: a reference filter model pushes expected alarm
// vectors per scan into a queue, popped and compared when pronto appears.
module tb_monitor_limites;
    localparam int NC = 3;

    logic        clock = 1'b0;
    logic        reset, medir;
    logic [15:0] val [5];
    logic [15:0] lim [5];
    logic [3:0]  alarme_temp;
    logic        alarme_umidade, alarme_algum, pronto, ocupado;
    logic [1:0]  db_estado;

    int n_vec = 0;
    int n_err = 0;

    bit [4:0] m_al;
    int       m_cnt [5];
    logic [4:0] sb [$];

    monitor_limites #(.N_CONFIRMA(NC), .HIST(16)) dut (
        .clock(clock), .reset(reset), .medir(medir),
        .temp1(val[0]), .temp2(val[1]), .temp3(val[2]), .temp4(val[3]), .umidade(val[4]),
        .temp_lim1(lim[0]), .temp_lim2(lim[1]), .temp_lim3(lim[2]), .temp_lim4(lim[3]),
        .umidade_lim(lim[4]),
        .alarme_temp(alarme_temp), .alarme_umidade(alarme_umidade), .alarme_algum(alarme_algum),
        .pronto(pronto), .ocupado(ocupado), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_al = '0;
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    endfunction

    function automatic void model_scan();
        for (int i = 0; i < 5; i++) begin
            int lb;
            bit cond;
            lb = int'(lim[i]);
`ifdef HISTERESE_EN
            lb = (lim[i] >= 16) ? int'(lim[i]) - 16 : 0;
`endif
            cond = m_al[i] ? (int'(val[i]) <= lb) : (val[i] > lim[i]);
            if (!cond) m_cnt[i] = 0;
            else if (m_cnt[i] + 1 == NC) begin
                m_al[i]  = ~m_al[i];
                m_cnt[i] = 0;
            end else m_cnt[i]++;
        end
    endfunction

    // One scan of fixed length; 'timed' adds cycle-exact checks, 'extra' re-raises medir
    // mid-scan, 'chg' changes temp2 right after the accepting edge.
    task automatic scan(input bit timed, input bit extra, input bit chg, input string tag);
        bit seen;
        bit pre0, post0;
        seen = 0;
        pre0 = m_al[0];
        model_scan();
        post0 = m_al[0];
        sb.push_back(m_al);
        @(negedge clock) medir = 1'b1;
        @(posedge clock);
        for (int c = 0; c < 7; c++) begin
            @(negedge clock);
            medir = extra && (c == 1 || c == 4);
            if (chg && c == 0) val[1] = 16'hFFFF;
            if (timed) begin
                check({tag, "_pronto"}, 32'(pronto), 32'(c == 5));
                check({tag, "_ocupado"}, 32'(ocupado), 32'(c < 6));
                check({tag, "_estado"}, 32'(db_estado), (c < 5) ? 32'd1 : (c == 5) ? 32'd2 : 32'd0);
                if (c == 0) check({tag, "_al0_k"}, 32'(alarme_temp[0]), 32'(pre0));
                if (c == 1) check({tag, "_al0_k1"}, 32'(alarme_temp[0]), 32'(post0));
            end
            if (pronto === 1'b1 && sb.size() > 0) begin
                logic [4:0] e;
                seen = 1;
                e = sb.pop_front();
                check({tag, "_alarmes"}, 32'({alarme_umidade, alarme_temp}), 32'(e));
                check({tag, "_algum"}, 32'(alarme_algum), 32'(|e));
            end
        end
        check({tag, "_pronto_seen"}, 32'(seen), 32'd1);
        if (extra) begin
            repeat (4) begin
                @(negedge clock);
                check({tag, "_noextra"}, 32'({pronto, db_estado}), 32'd0);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        medir = 1'b1;
        for (int i = 0; i < 5; i++) begin
            val[i] = 16'hFFFF;
            lim[i] = 16'hFFFF;
        end
        model_reset();

        // Reset dominates a held medir
        repeat (2) begin
            @(posedge clock);
            @(negedge clock);
            check("rst_outs", 32'({alarme_temp, alarme_umidade, alarme_algum, pronto, ocupado, db_estado}), 32'd0);
        end
        reset = 1'b0;
        medir = 1'b0;
        for (int i = 0; i < 5; i++) begin
            val[i] = 16'd0;
            lim[i] = 16'd1000;
        end

        // Confirmation: alarm sets on the third consecutive excess
        val[0] = 16'd100;
        lim[0] = 16'd90;
        scan(0, 0, 0, "conf1");
        scan(0, 0, 0, "conf2");
        scan(1, 0, 0, "conf3");

        // Hysteresis band (85 inside band, 74 below it)
        val[0] = 16'd85;
        repeat (3) scan(0, 0, 0, "hist85");
        val[0] = 16'd74;
        repeat (3) scan(0, 0, 0, "hist74");

        // Broken run of excess never confirms
        val[0] = 16'd100; scan(0, 0, 0, "seq1");
        scan(0, 0, 0, "seq2");
        val[0] = 16'd80;  scan(0, 0, 0, "seq3");
        val[0] = 16'd100; scan(0, 0, 0, "seq4");
        scan(0, 0, 0, "seq5");
        val[0] = 16'd80;  scan(0, 0, 0, "seq6");

        // Humidity with limit below HIST: clear threshold saturates at 0
        lim[4] = 16'd10;
        val[4] = 16'd20;
        repeat (3) scan(0, 0, 0, "sat_set");
        val[4] = 16'd5;
        repeat (3) scan(0, 0, 0, "sat5");
        val[4] = 16'd0;
        repeat (3) scan(0, 0, 0, "sat0");

        // Handshake: snapshot isolation and ignored mid-scan medir
        val[1] = 16'd2000;
        repeat (2) scan(0, 0, 0, "hs_pre");
        val[1] = 16'd0;
        scan(1, 1, 1, "hs");
        val[1] = 16'd0;
        scan(0, 0, 0, "hs_post");

        // Reset mid-scan with alarms set
        val[0] = 16'd100;
        val[2] = 16'd5000;
        repeat (3) scan(0, 0, 0, "mid_set");
        check("mid_pre", 32'(alarme_temp), 32'h5);
        @(negedge clock) medir = 1'b1;
        @(posedge clock);
        @(negedge clock) medir = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_al", 32'({alarme_umidade, alarme_temp, alarme_algum}), 32'd0);
        check("mid_rst_st", 32'({pronto, ocupado, db_estado}), 32'd0);
        reset = 1'b0;
        model_reset();
        repeat (8) begin
            @(negedge clock);
            check("mid_nopronto", 32'(pronto), 32'd0);
        end
        scan(0, 0, 0, "after_rst");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
